// File: rtl/mipi_delay_cal.sv
// ---------------------------------------------------------------------------
// mipi_delay_cal
//
// Calibration controller for the MIPI PHY deserializer input delay taps.
// After a start request it walks every IDELAY tap from 0 to the top tap. For
// each tap it loads the tap into the PHY and waits for the delay line to
// settle. It then counts sync-byte detections from the lane aligner over a
// fixed window and scores the tap as passing or failing. It tracks the
// longest contiguous run of passing taps, keeping the earlier run on a tie.
// At the end it loads the centre tap of that run (rounded down), or tap 0
// with the fail flag set when no tap passed.
//
// Ports:
//   clk_i        controller clock, same domain as the PHY delay-control clock
//   resetb_i     asynchronous active-low reset
//   start_i      single-cycle sweep request, accepted only when idle
//   sync_hit_i   single-cycle pulse per sync byte seen by the lane aligner
//   del_val_o    delay tap value presented to the PHY (held between loads)
//   del_ld_o     single-cycle load strobe for del_val_o
//   busy_o       sweep in progress
//   done_o       single-cycle pulse when the sweep completes
//   fail_o       sticky "no tap passed" flag, cleared by the next start
//   win_start_o  first tap of the best passing run
//   win_len_o    length of the best passing run, 0 if none
// ---------------------------------------------------------------------------
module mipi_delay_cal #(
   parameter int TAP_BITS      = 5,
   parameter int SETTLE_CYCLES = 16,
   parameter int WINDOW_CYCLES = 4096,
   parameter int MIN_HITS      = 2
) (
   input  logic                clk_i,
   input  logic                resetb_i,
   input  logic                start_i,
   input  logic                sync_hit_i,
   output logic [TAP_BITS-1:0] del_val_o,
   output logic                del_ld_o,
   output logic                busy_o,
   output logic                done_o,
   output logic                fail_o,
   output logic [TAP_BITS-1:0] win_start_o,
   output logic [TAP_BITS:0]   win_len_o
);

   // One shared counter times both the settle wait and the measurement window.
   localparam int CNT_MAX = (WINDOW_CYCLES > SETTLE_CYCLES) ? WINDOW_CYCLES : SETTLE_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX) + 1;
   localparam logic [CNT_W-1:0]    SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0]    WINDOW_LAST = CNT_W'(WINDOW_CYCLES - 1);
   localparam logic [7:0]          HITS_MAX    = 8'd255;
   localparam logic [7:0]          HITS_MIN    = 8'(MIN_HITS);
   localparam logic [TAP_BITS-1:0] TAP_LAST    = '1;

   typedef enum logic [2:0] {
      IDLE, LOAD, SETTLE, MEASURE, EVAL, APPLY, DONE
   } state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [7:0]          hits_q, hits_d;
   logic [TAP_BITS-1:0] tap_q, tap_d;
   logic [TAP_BITS-1:0] curStart_q, curStart_d;
   logic [TAP_BITS:0]   curLen_q, curLen_d;
   logic [TAP_BITS-1:0] bestStart_q, bestStart_d;
   logic [TAP_BITS:0]   bestLen_q, bestLen_d;
   logic [TAP_BITS-1:0] delVal_q, delVal_d;
   logic [TAP_BITS-1:0] winStart_q, winStart_d;
   logic [TAP_BITS:0]   winLen_q, winLen_d;
   logic                fail_q, fail_d;

   logic                tapPass;
   logic [TAP_BITS-1:0] runStart;
   logic [TAP_BITS:0]   runLen;
   logic [TAP_BITS-1:0] centreTap;

   // Scoring helpers for the tap just measured. A passing tap either opens a
   // new run at the current tap or extends the run already in progress. The
   // centre is taken from the best run as it stands after this tap, so that
   // the final tap's contribution is included when we leave for APPLY.
   always_comb begin
      tapPass   = (hits_q >= HITS_MIN);
      runStart  = (curLen_q == '0) ? tap_q : curStart_q;
      runLen    = curLen_q + 1'b1;
      centreTap = bestStart_d + TAP_BITS'((bestLen_d - 1'b1) >> 1);
   end

   // Next-state and datapath updates for the sweep sequencer. Every register
   // holds by default; each state only touches what it owns. The outgoing
   // del_val is registered and updated on the edge into LOAD or APPLY so it is
   // already stable in the cycle that carries the load strobe.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      hits_d      = hits_q;
      tap_d       = tap_q;
      curStart_d  = curStart_q;
      curLen_d    = curLen_q;
      bestStart_d = bestStart_q;
      bestLen_d   = bestLen_q;
      delVal_d    = delVal_q;
      winStart_d  = winStart_q;
      winLen_d    = winLen_q;
      fail_d      = fail_q;

      case (state_q)
         IDLE: begin
            if (start_i) begin
               tap_d       = '0;
               curLen_d    = '0;
               bestLen_d   = '0;
               bestStart_d = '0;
               fail_d      = 1'b0;
               delVal_d    = '0;
               state_d     = LOAD;
            end
         end
         LOAD: begin
            cnt_d   = '0;
            state_d = SETTLE;
         end
         SETTLE: begin
            if (cnt_q == SETTLE_LAST) begin
               cnt_d   = '0;
               hits_d  = '0;
               state_d = MEASURE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         MEASURE: begin
            if (sync_hit_i && (hits_q != HITS_MAX)) begin
               hits_d = hits_q + 1'b1;
            end
            if (cnt_q == WINDOW_LAST) begin
               state_d = EVAL;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         EVAL: begin
            if (tapPass) begin
               curStart_d = runStart;
               curLen_d   = runLen;
               if (runLen > bestLen_q) begin
                  bestStart_d = runStart;
                  bestLen_d   = runLen;
               end
            end else begin
               curLen_d = '0;
            end
            if (tap_q == TAP_LAST) begin
               delVal_d = (bestLen_d == '0) ? '0 : centreTap;
               state_d  = APPLY;
            end else begin
               tap_d    = tap_q + 1'b1;
               delVal_d = tap_q + 1'b1;
               state_d  = LOAD;
            end
         end
         APPLY: begin
            fail_d     = (bestLen_q == '0);
            winStart_d = bestStart_q;
            winLen_d   = bestLen_q;
            state_d    = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers. Reset aborts any sweep in progress and
   // returns every visible output to zero.
   always_ff @(posedge clk_i or negedge resetb_i) begin
      if (!resetb_i) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         hits_q      <= '0;
         tap_q       <= '0;
         curStart_q  <= '0;
         curLen_q    <= '0;
         bestStart_q <= '0;
         bestLen_q   <= '0;
         delVal_q    <= '0;
         winStart_q  <= '0;
         winLen_q    <= '0;
         fail_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         hits_q      <= hits_d;
         tap_q       <= tap_d;
         curStart_q  <= curStart_d;
         curLen_q    <= curLen_d;
         bestStart_q <= bestStart_d;
         bestLen_q   <= bestLen_d;
         delVal_q    <= delVal_d;
         winStart_q  <= winStart_d;
         winLen_q    <= winLen_d;
         fail_q      <= fail_d;
      end
   end

   // Strobes and status decode straight from the state. busy drops in DONE so
   // the host sees done and not-busy together.
   always_comb begin
      del_val_o   = delVal_q;
      del_ld_o    = (state_q == LOAD) || (state_q == APPLY);
      busy_o      = (state_q != IDLE) && (state_q != DONE);
      done_o      = (state_q == DONE);
      fail_o      = fail_q;
      win_start_o = winStart_q;
      win_len_o   = winLen_q;
   end

endmodule

// File: tb/tb_mipi_delay_cal.sv
// ---------------------------------------------------------------------------
// tb_mipi_delay_cal
//
// Self-checking bench for mipi_delay_cal with a short settle and window.
// Each sweep is driven from a per-tap hit count table. The bench places that
// many sync_hit pulses inside each tap's measurement window and toggles
// sync_hit randomly in the settle and evaluate cycles, where it must be
// ignored. Expected results come from a fixed vector table, and for the
// randomized sweeps from a run-search model over the per-tap hit counts.
// ---------------------------------------------------------------------------
module tb_mipi_delay_cal;

   localparam int TAP_BITS      = 5;
   localparam int NUM_TAPS      = 32;
   localparam int SETTLE_CYCLES = 2;
   localparam int WINDOW_CYCLES = 16;
   localparam int MIN_HITS      = 2;

   logic                clk;
   logic                resetb;
   logic                start;
   logic                sync_hit;
   logic [TAP_BITS-1:0] del_val;
   logic                del_ld;
   logic                busy;
   logic                done;
   logic                fail;
   logic [TAP_BITS-1:0] win_start;
   logic [TAP_BITS:0]   win_len;

   int checkCount = 0;
   int errorCount = 0;
   int ldCount    = 0;
   int doneCount  = 0;
   int hitsPerTap [NUM_TAPS];

   typedef struct {
      logic [31:0] passMask;
      int          hitsPass;
      int          hitsFail;
      int          expStart;
      int          expLen;
      int          expDelVal;
      bit          expFail;
   } vec_t;

   vec_t vecs [8];

   mipi_delay_cal #(
      .TAP_BITS      (TAP_BITS),
      .SETTLE_CYCLES (SETTLE_CYCLES),
      .WINDOW_CYCLES (WINDOW_CYCLES),
      .MIN_HITS      (MIN_HITS)
   ) dut (
      .clk_i       (clk),
      .resetb_i    (resetb),
      .start_i     (start),
      .sync_hit_i  (sync_hit),
      .del_val_o   (del_val),
      .del_ld_o    (del_ld),
      .busy_o      (busy),
      .done_o      (done),
      .fail_o      (fail),
      .win_start_o (win_start),
      .win_len_o   (win_len)
   );

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Count load strobes and done pulses on the falling edge, well away from
   // the edge that moves the DUT.
   always @(negedge clk) begin
      if (del_ld) ldCount++;
      if (done)   doneCount++;
   end

   task automatic waitCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Reference model: scan for maximal runs of passing taps and keep the first
   // longest one.
   task automatic computeExpected(output int eStart, output int eLen, output int eDel);
      int runLen;
      bit opens;
      eStart = 0;
      eLen   = 0;
      for (int s = 0; s < NUM_TAPS; s++) begin
         opens = (hitsPerTap[s] >= MIN_HITS);
         if (opens && s > 0) begin
            if (hitsPerTap[s-1] >= MIN_HITS) opens = 1'b0;
         end
         if (opens) begin
            runLen = 0;
            while (s + runLen < NUM_TAPS && hitsPerTap[s + runLen] >= MIN_HITS) runLen++;
            if (runLen > eLen) begin
               eLen   = runLen;
               eStart = s;
            end
         end
      end
      eDel = (eLen == 0) ? 0 : eStart + (eLen - 1) / 2;
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_delVal"},   64'(del_val),   64'd0);
      checkOutput({tag, "_delLd"},    64'(del_ld),    64'd0);
      checkOutput({tag, "_busy"},     64'(busy),      64'd0);
      checkOutput({tag, "_done"},     64'(done),      64'd0);
      checkOutput({tag, "_fail"},     64'(fail),      64'd0);
      checkOutput({tag, "_winStart"}, 64'(win_start), 64'd0);
      checkOutput({tag, "_winLen"},   64'(win_len),   64'd0);
   endtask

   // Run one sweep from the idle state using hitsPerTap. Called one cycle
   // after the previous DONE, so start is accepted back-to-back. midStart
   // holds start high across tap 5, which must be ignored. abortTap >= 0
   // asserts reset inside that tap's measurement window and returns at once.
   task automatic applyStimulus(input string name, input bit midStart, input int abortTap,
                                input int eStart, input int eLen, input int eDel, input bit eFail);
      int ldBase;
      int doneBase;
      int off;
      ldBase   = ldCount;
      doneBase = doneCount;
      start = 1'b1;
      waitCycle();
      start = 1'b0;
      for (int t = 0; t < NUM_TAPS; t++) begin
         checkOutput({name, "_loadTap"}, 64'({del_ld, del_val}), 64'({1'b1, 5'(t)}));
         if (t == 7) checkOutput({name, "_busyMid"}, 64'(busy), 64'd1);
         off = $urandom_range(0, WINDOW_CYCLES - 1);
         for (int k = 1; k <= 19; k++) begin
            waitCycle();
            if (k >= 3 && k <= 18)
               sync_hit = ((((k - 3) + off) % WINDOW_CYCLES) < hitsPerTap[t]);
            else
               sync_hit = 1'($urandom_range(0, 1));
            start = midStart && (t == 5);
            if (t == abortTap && k == 5) begin
               resetb   = 1'b0;
               sync_hit = 1'b0;
               start    = 1'b0;
               return;
            end
         end
         waitCycle();
         sync_hit = 1'b0;
         start    = 1'b0;
      end
      checkOutput({name, "_applyLoad"}, 64'({del_ld, del_val}), 64'({1'b1, 5'(eDel)}));
      waitCycle();
      checkOutput({name, "_done"},     64'({done, busy}), 64'({1'b1, 1'b0}));
      checkOutput({name, "_winStart"}, 64'(win_start),    64'(eStart));
      checkOutput({name, "_winLen"},   64'(win_len),      64'(eLen));
      checkOutput({name, "_fail"},     64'(fail),         64'(eFail));
      checkOutput({name, "_delVal"},   64'(del_val),      64'(eDel));
      waitCycle();
      checkOutput({name, "_idle"},      64'({done, busy, del_ld}), 64'd0);
      checkOutput({name, "_ldCount"},   64'(ldCount - ldBase),     64'd33);
      checkOutput({name, "_doneCount"}, 64'(doneCount - doneBase), 64'd1);
   endtask

   task automatic loadVector(input int idx);
      for (int t = 0; t < NUM_TAPS; t++)
         hitsPerTap[t] = vecs[idx].passMask[t] ? vecs[idx].hitsPass : vecs[idx].hitsFail;
   endtask

   initial begin
      int eStart;
      int eLen;
      int eDel;

      vecs[0] = '{32'hFFFF_FFFF, 4, 0,  0, 32, 15, 1'b0};
      vecs[1] = '{32'h0003_FC00, 4, 0, 10,  8, 13, 1'b0};
      vecs[2] = '{32'h0FF0_0038, 4, 0, 20,  8, 23, 1'b0};
      vecs[3] = '{32'h0000_F03C, 4, 0,  2,  4,  3, 1'b0};
      vecs[4] = '{32'h0000_0000, 4, 0,  0,  0,  0, 1'b1};
      vecs[5] = '{32'h0000_0000, 4, 1,  0,  0,  0, 1'b1};
      vecs[6] = '{32'hC000_0000, 2, 1, 30,  2, 30, 1'b0};
      vecs[7] = '{32'h8000_0001, 3, 1,  0,  1,  0, 1'b0};

      resetb   = 1'b0;
      start    = 1'b0;
      sync_hit = 1'b0;
      repeat (3) waitCycle();
      checkResetValues("reset");
      resetb = 1'b1;
      waitCycle();
      waitCycle();

      // Fixed vectors, run back-to-back.
      for (int v = 0; v < 8; v++) begin
         loadVector(v);
         applyStimulus($sformatf("vec%0d", v), 1'b0, -1,
                       vecs[v].expStart, vecs[v].expLen, vecs[v].expDelVal, vecs[v].expFail);
      end

      // Leave a non-zero result behind, then abort in tap 9's window.
      loadVector(1);
      applyStimulus("preAbort", 1'b0, -1, 10, 8, 13, 1'b0);
      loadVector(0);
      applyStimulus("abort", 1'b0, 9, 0, 0, 0, 1'b0);
      #1;
      checkResetValues("abortNow");
      waitCycle();
      waitCycle();
      checkResetValues("abortHeld");
      resetb = 1'b1;
      waitCycle();

      // Clean sweep after the abort, with start held high during tap 5.
      loadVector(2);
      applyStimulus("midStart", 1'b1, -1, 20, 8, 23, 1'b0);

      // Randomized sweeps against the run-search model.
      for (int r = 0; r < 5; r++) begin
         for (int t = 0; t < NUM_TAPS; t++)
            hitsPerTap[t] = ($urandom_range(0, 99) < 65) ? int'($urandom_range(2, 16))
                                                         : int'($urandom_range(0, 1));
         computeExpected(eStart, eLen, eDel);
         applyStimulus($sformatf("rand%0d", r), 1'b0, -1, eStart, eLen, eDel, eLen == 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
